// File: rtl/axis_snoop_writer_pkg.sv
// Shared definitions for the AXI-Stream snoop writer.
// Holds the FSM state encoding, the drop counter width and a 4-bit popcount.
package axis_snoop_writer_pkg;

    typedef enum logic [2:0] {
        ST_RESYNC  = 3'd0,
        ST_IDLE    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_TRUNC   = 3'd3,
        ST_DROP    = 3'd4
    } state_t;

    localparam int DROP_CNT_W = 16;

    function automatic logic [2:0] popcount4(input logic [3:0] k);
        return 3'(k[0]) + 3'(k[1]) + 3'(k[2]) + 3'(k[3]);
    endfunction

endpackage

// File: rtl/axis_snoop_writer.sv
// Write-side sequencer that copies snooped stream packets into the granted buffer.
// Ports: clk, rst_n (sync, active low); s_* stream tap; ready_for_snooper grant;
// snooper_wr_* buffer write port; snooper_done EOP pulse; pkt_* / drop_cnt status.
module axis_snoop_writer
    import axis_snoop_writer_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             s_tdata,
    input  logic [3:0]              s_tkeep,
    input  logic                    s_tvalid,
    input  logic                    s_tlast,
    input  logic                    ready_for_snooper,
    output logic [ADDR_WIDTH-1:0]   snooper_wr_addr,
    output logic [31:0]             snooper_wr_data,
    output logic                    snooper_wr_en,
    output logic                    snooper_done,
    output logic [ADDR_WIDTH+2:0]   pkt_byte_len,
    output logic                    pkt_trunc,
    output logic [DROP_CNT_W-1:0]   drop_cnt,
    output logic [31:0]             pkt_cnt
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int LEN_W = ADDR_WIDTH + 3;
    localparam logic [CNT_W-1:0] CAP_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [LEN_W-1:0] CAP_BYTES = {1'b1, {(ADDR_WIDTH+2){1'b0}}};

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   wcnt, wcnt_nxt;

    logic               stg_valid;
    logic [31:0]        stg_data;
    logic [3:0]         stg_keep;
    logic               stg_last;

    logic               wr_en_c;
    logic               done_c;
    logic               trunc_c;
    logic [LEN_W-1:0]   len_c;
    logic               drop_inc;
    logic [LEN_W-1:0]   keep_bytes;

    assign keep_bytes = LEN_W'(popcount4(stg_keep));

    // Input stage: free-running register, no backpressure on the tap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg_valid <= 1'b0;
            stg_data  <= '0;
            stg_keep  <= '0;
            stg_last  <= 1'b0;
        end else begin
            stg_valid <= s_tvalid;
            stg_data  <= s_tdata;
            stg_keep  <= s_tkeep;
            stg_last  <= s_tlast;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RESYNC;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // wcnt is cleared on every path back to IDLE or into DROP so the
    // next SOP always writes address 0 straight from wcnt.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        wr_en_c   = 1'b0;
        done_c    = 1'b0;
        trunc_c   = 1'b0;
        len_c     = '0;
        drop_inc  = 1'b0;
        if (stg_valid) begin
            unique case (state)
                ST_RESYNC: begin
                    if (stg_last) state_nxt = ST_IDLE;
                end
                ST_IDLE: begin
                    if (ready_for_snooper) begin
                        wr_en_c = 1'b1;
                        if (stg_last) begin
                            done_c   = 1'b1;
                            len_c    = keep_bytes;
                            wcnt_nxt = '0;
                        end else begin
                            wcnt_nxt  = CNT_W'(1);
                            state_nxt = ST_CAPTURE;
                        end
                    end else begin
                        drop_inc = 1'b1;
                        if (!stg_last) state_nxt = ST_DROP;
                    end
                end
                ST_CAPTURE: begin
                    if (!ready_for_snooper) begin
                        // Grant withdrawn mid-packet: abandon it silently.
                        drop_inc  = 1'b1;
                        wcnt_nxt  = '0;
                        state_nxt = stg_last ? ST_IDLE : ST_DROP;
                    end else if (wcnt != CAP_WORDS) begin
                        wr_en_c  = 1'b1;
                        wcnt_nxt = wcnt + CNT_W'(1);
                        if (stg_last) begin
                            done_c    = 1'b1;
                            len_c     = {wcnt, 2'b00} + keep_bytes;
                            wcnt_nxt  = '0;
                            state_nxt = ST_IDLE;
                        end
                    end else if (stg_last) begin
                        done_c    = 1'b1;
                        trunc_c   = 1'b1;
                        len_c     = CAP_BYTES;
                        wcnt_nxt  = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_TRUNC;
                    end
                end
                ST_TRUNC: begin
                    if (stg_last) begin
                        done_c    = 1'b1;
                        trunc_c   = 1'b1;
                        len_c     = CAP_BYTES;
                        wcnt_nxt  = '0;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (stg_last) state_nxt = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_RESYNC;
                    wcnt_nxt  = '0;
                end
            endcase
        end
    end

    assign snooper_wr_addr = wcnt[ADDR_WIDTH-1:0];
    assign snooper_wr_data = stg_data;
    assign snooper_wr_en   = wr_en_c;
    assign snooper_done    = done_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_byte_len <= '0;
            pkt_trunc    <= 1'b0;
            pkt_cnt      <= '0;
            drop_cnt     <= '0;
        end else begin
            if (done_c) begin
                pkt_byte_len <= len_c;
                pkt_trunc    <= trunc_c;
                pkt_cnt      <= pkt_cnt + 32'd1;
            end
            if (drop_inc && drop_cnt != '1) begin
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_snoop_writer.sv
// Directed testbench for axis_snoop_writer with ADDR_WIDTH=4 (16-word buffers).
// Beats are queued per scenario and replayed; a monitor logs writes and done pulses.
module tb_axis_snoop_writer;

    localparam int AW = 4;

    logic           clk;
    logic           rst_n;
    logic [31:0]    s_tdata;
    logic [3:0]     s_tkeep;
    logic           s_tvalid;
    logic           s_tlast;
    logic           ready;
    logic [AW-1:0]  wr_addr;
    logic [31:0]    wr_data;
    logic           wr_en;
    logic           done;
    logic [AW+2:0]  byte_len;
    logic           trunc;
    logic [15:0]    drop_cnt;
    logic [31:0]    pkt_cnt;

    axis_snoop_writer #(.ADDR_WIDTH(AW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_tdata           (s_tdata),
        .s_tkeep           (s_tkeep),
        .s_tvalid          (s_tvalid),
        .s_tlast           (s_tlast),
        .ready_for_snooper (ready),
        .snooper_wr_addr   (wr_addr),
        .snooper_wr_data   (wr_data),
        .snooper_wr_en     (wr_en),
        .snooper_done      (done),
        .pkt_byte_len      (byte_len),
        .pkt_trunc         (trunc),
        .drop_cnt          (drop_cnt),
        .pkt_cnt           (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        r;
        logic        rs;
    } beat_t;

    beat_t       seq[$];
    int          wa_q[$];
    logic [31:0] wd_q[$];
    int          done_n;
    int          done_wr_n;
    int          pass_n;
    int          total_n;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa_q.push_back(int'(wr_addr));
            wd_q.push_back(wr_data);
        end
        if (done === 1'b1) begin
            done_n++;
            if (wr_en === 1'b1) done_wr_n++;
        end
    end

    task automatic clear_logs();
        wa_q.delete();
        wd_q.delete();
        done_n    = 0;
        done_wr_n = 0;
    endtask

    // r: ready level while this beat sits in the stage; rs: rst_n while driving it.
    task automatic add(input logic [31:0] d, input logic [3:0] k,
                       input logic l, input logic r, input logic rs = 1'b1);
        beat_t b;
        b.v = 1'b1; b.d = d; b.k = k; b.l = l; b.r = r; b.rs = rs;
        seq.push_back(b);
    endtask

    task automatic run();
        for (int i = 0; i <= seq.size(); i++) begin
            @(posedge clk);
            #1;
            if (i > 0) ready = seq[i-1].r;
            if (i < seq.size()) begin
                rst_n    = seq[i].rs;
                s_tvalid = seq[i].v;
                s_tdata  = seq[i].d;
                s_tkeep  = seq[i].k;
                s_tlast  = seq[i].l;
            end else begin
                rst_n    = 1'b1;
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        seq.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ready = 1'b1;
        s_tvalid = 1'b1; s_tdata = 32'hDEAD_BEEF; s_tkeep = 4'hF; s_tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_n++;
        if (wr_en !== 1'b0 || done !== 1'b0) $display("FAIL reset_strobes: wr_en=%b done=%b want 0 0", wr_en, done);
        else pass_n++;
        total_n++;
        if (wr_addr !== '0 || wr_data !== '0) $display("FAIL reset_wr_port: addr=%0d data=%h want 0 0", wr_addr, wr_data);
        else pass_n++;
        total_n++;
        if (byte_len !== '0 || trunc !== 1'b0) $display("FAIL reset_len: len=%0d trunc=%b want 0 0", byte_len, trunc);
        else pass_n++;
        total_n++;
        if (drop_cnt !== '0 || pkt_cnt !== '0) $display("FAIL reset_cnt: drop=%0d pkt=%0d want 0 0", drop_cnt, pkt_cnt);
        else pass_n++;
        s_tvalid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_resync_and_basic();
        clear_logs();
        add(32'h1000_0000, 4'hF, 1'b0, 1'b1);
        add(32'h1000_0001, 4'hF, 1'b0, 1'b1);
        add(32'h1000_0002, 4'h3, 1'b1, 1'b1);
        run();
        total_n++;
        if (wa_q.size() != 0 || done_n != 0) $display("FAIL resync_discard: writes=%0d dones=%0d want 0 0", wa_q.size(), done_n);
        else pass_n++;
        clear_logs();
        add(32'hA000_0000, 4'hF, 1'b0, 1'b1);
        add(32'hA000_0001, 4'hF, 1'b0, 1'b1);
        add(32'hA000_0002, 4'h3, 1'b1, 1'b1);
        run();
        total_n++;
        if (wa_q.size() != 3 || wa_q[0] != 0 || wa_q[1] != 1 || wa_q[2] != 2)
            $display("FAIL basic_addr: writes=%0d want addrs 0,1,2", wa_q.size());
        else pass_n++;
        total_n++;
        if (wd_q.size() != 3 || wd_q[0] !== 32'hA000_0000 || wd_q[2] !== 32'hA000_0002)
            $display("FAIL basic_data: n=%0d want A0000000..A0000002", wd_q.size());
        else pass_n++;
        total_n++;
        if (done_n != 1 || done_wr_n != 1) $display("FAIL basic_done: dones=%0d with_wr=%0d want 1 1", done_n, done_wr_n);
        else pass_n++;
        total_n++;
        if (byte_len !== 7'd10 || pkt_cnt !== 32'd1 || trunc !== 1'b0)
            $display("FAIL basic_len: len=%0d pkt=%0d trunc=%b want 10 1 0", byte_len, pkt_cnt, trunc);
        else pass_n++;
    endtask

    task automatic test_back_to_back();
        clear_logs();
        add(32'hB000_0000, 4'hF, 1'b1, 1'b1);
        add(32'hB000_0001, 4'hF, 1'b0, 1'b0);
        add(32'hB000_0002, 4'hF, 1'b1, 1'b0);
        run();
        total_n++;
        if (wa_q.size() != 1 || wa_q[0] != 0 || done_n != 1 || done_wr_n != 1)
            $display("FAIL b2b_writes: writes=%0d dones=%0d want 1 1", wa_q.size(), done_n);
        else pass_n++;
        total_n++;
        if (byte_len !== 7'd4 || drop_cnt !== 16'd1 || pkt_cnt !== 32'd2)
            $display("FAIL b2b_status: len=%0d drop=%0d pkt=%0d want 4 1 2", byte_len, drop_cnt, pkt_cnt);
        else pass_n++;
    endtask

    task automatic test_truncate();
        logic ok;
        clear_logs();
        for (int i = 0; i < 20; i++)
            add(32'hC000_0000 + 32'(i), 4'hF, (i == 19), 1'b1);
        run();
        ok = (wa_q.size() == 16);
        for (int i = 0; i < 16 && ok; i++) ok = (wa_q[i] == i);
        total_n++;
        if (!ok) $display("FAIL trunc_addr: writes=%0d want 16 in order 0..15", wa_q.size());
        else pass_n++;
        total_n++;
        if (wd_q.size() != 16 || wd_q[15] !== 32'hC000_000F)
            $display("FAIL trunc_data: n=%0d want last C000000F", wd_q.size());
        else pass_n++;
        total_n++;
        if (done_n != 1 || done_wr_n != 0) $display("FAIL trunc_done: dones=%0d with_wr=%0d want 1 0", done_n, done_wr_n);
        else pass_n++;
        total_n++;
        if (trunc !== 1'b1 || byte_len !== 7'd64 || pkt_cnt !== 32'd3)
            $display("FAIL trunc_status: trunc=%b len=%0d pkt=%0d want 1 64 3", trunc, byte_len, pkt_cnt);
        else pass_n++;
    endtask

    task automatic test_drop_at_sop();
        clear_logs();
        for (int i = 0; i < 4; i++) add(32'hD000_0000 + 32'(i), 4'hF, (i == 3), 1'b0);
        add(32'hD100_0000, 4'hF, 1'b0, 1'b1);
        add(32'hD100_0001, 4'h7, 1'b1, 1'b1);
        run();
        total_n++;
        if (wa_q.size() != 2 || wa_q[0] != 0 || wa_q[1] != 1 || done_n != 1 || done_wr_n != 1)
            $display("FAIL sopdrop_writes: writes=%0d dones=%0d want 2 1", wa_q.size(), done_n);
        else pass_n++;
        total_n++;
        if (drop_cnt !== 16'd2 || byte_len !== 7'd7 || trunc !== 1'b0 || pkt_cnt !== 32'd4)
            $display("FAIL sopdrop_status: drop=%0d len=%0d trunc=%b pkt=%0d want 2 7 0 4",
                     drop_cnt, byte_len, trunc, pkt_cnt);
        else pass_n++;
    endtask

    task automatic test_mid_reset();
        clear_logs();
        for (int i = 0; i < 6; i++)
            add(32'hE000_0000 + 32'(i), 4'hF, (i == 5), 1'b1, (i == 2) ? 1'b0 : 1'b1);
        add(32'hE100_0000, 4'hF, 1'b0, 1'b1);
        add(32'hE100_0001, 4'hF, 1'b1, 1'b1);
        run();
        total_n++;
        if (wa_q.size() != 4 || wa_q[1] != 1 || wa_q[2] != 0 || wa_q[3] != 1)
            $display("FAIL rst_writes: writes=%0d want addrs 0,1,0,1", wa_q.size());
        else pass_n++;
        total_n++;
        if (wd_q.size() != 4 || wd_q[2] !== 32'hE100_0000)
            $display("FAIL rst_data: n=%0d want 3rd write E1000000", wd_q.size());
        else pass_n++;
        total_n++;
        if (done_n != 1 || pkt_cnt !== 32'd1 || byte_len !== 7'd8 || drop_cnt !== 16'd0)
            $display("FAIL rst_status: dones=%0d pkt=%0d len=%0d drop=%0d want 1 1 8 0",
                     done_n, pkt_cnt, byte_len, drop_cnt);
        else pass_n++;
    endtask

    task automatic test_ready_fall();
        clear_logs();
        for (int i = 0; i < 5; i++)
            add(32'hF000_0000 + 32'(i), 4'hF, (i == 4), (i == 0));
        run();
        total_n++;
        if (wa_q.size() != 1 || wa_q[0] != 0 || done_n != 0 || drop_cnt !== 16'd1)
            $display("FAIL fall_drop: writes=%0d dones=%0d drop=%0d want 1 0 1", wa_q.size(), done_n, drop_cnt);
        else pass_n++;
        clear_logs();
        add(32'hF100_0000, 4'h1, 1'b1, 1'b1);
        run();
        total_n++;
        if (wa_q.size() != 1 || wa_q[0] != 0 || done_n != 1 || byte_len !== 7'd1 || pkt_cnt !== 32'd2)
            $display("FAIL fall_recover: writes=%0d dones=%0d len=%0d pkt=%0d want 1 1 1 2",
                     wa_q.size(), done_n, byte_len, pkt_cnt);
        else pass_n++;
    endtask

    initial begin
        pass_n = 0;
        total_n = 0;
        done_n = 0;
        done_wr_n = 0;
        rst_n = 1'b0;
        ready = 1'b0;
        s_tvalid = 1'b0;
        s_tdata = '0;
        s_tkeep = '0;
        s_tlast = 1'b0;
        test_reset();
        test_resync_and_basic();
        test_back_to_back();
        test_truncate();
        test_drop_at_sop();
        test_mid_reset();
        test_ready_fall();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
